// File: rtl/pipe_hazard_ctrl_pkg.sv
// pipe_ctrl_pkg: shared types and constants for the pipeline hazard controller
package pipe_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, DRAIN, VECTOR, ISR} irq_state_t;
  localparam logic [1:0] PC_SEL_SEQ = 2'd0;
  localparam logic [1:0] PC_SEL_BR  = 2'd1;
  localparam logic [1:0] PC_SEL_VEC = 2'd2;
  localparam logic [1:0] PC_SEL_EPC = 2'd3;
  localparam logic [3:0] REG_ZERO   = 4'd0;
endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if: pipeline status in, stall/flush/PC control out
interface pipe_hazard_ctrl_if #(parameter int CNT_W = 16);
  logic [3:0]       id_rs1, id_rs2, ex_reg_dst;
  logic             id_rs1_used, id_rs2_used, ex_mem_read, ex_branch_taken, ex_eret, dmem_busy, irq;
  logic             stall_if_id, stall_id_ex, stall_ex_mem, stall_mem_wb;
  logic             flush_if_id, flush_id_ex, flush_ex_mem, pc_hold;
  logic [1:0]       pc_sel;
  logic             epc_capture, irq_ack, int_active;
  logic [CNT_W-1:0] stall_cnt;
  modport master (
    input  id_rs1, id_rs2, ex_reg_dst, id_rs1_used, id_rs2_used, ex_mem_read,
           ex_branch_taken, ex_eret, dmem_busy, irq,
    output stall_if_id, stall_id_ex, stall_ex_mem, stall_mem_wb, flush_if_id, flush_id_ex,
           flush_ex_mem, pc_hold, pc_sel, epc_capture, irq_ack, int_active, stall_cnt
  );
  modport slave (
    output id_rs1, id_rs2, ex_reg_dst, id_rs1_used, id_rs2_used, ex_mem_read,
           ex_branch_taken, ex_eret, dmem_busy, irq,
    input  stall_if_id, stall_id_ex, stall_ex_mem, stall_mem_wb, flush_if_id, flush_id_ex,
           flush_ex_mem, pc_hold, pc_sel, epc_capture, irq_ack, int_active, stall_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl_load_use_detect.sv
// load_use_detect: flags an ID source that depends on the load currently in EX
module load_use_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [3:0] rs1_i,
  input  logic [3:0] rs2_i,
  input  logic       rs1_used_i,
  input  logic       rs2_used_i,
  input  logic [3:0] dst_i,
  input  logic       mem_read_i,
  output logic       hit_o
);
  assign hit_o = mem_read_i && dst_i != REG_ZERO &&
                 ((rs1_used_i && dst_i == rs1_i) || (rs2_used_i && dst_i == rs2_i));
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush/PC-select sequencing; interrupt path built only with PIPE_HAZARD_CTRL_IRQ_EN
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W = 16
) (
  input logic clk,
  input logic rst_n,
  pipe_hazard_ctrl_if.master bus
);
  localparam int DW = $clog2(DRAIN_CYCLES + 1);
  logic             lu_hit, in_drain, in_vec, eret_hit;
  logic             sif, fif, fid, fem, hold;
  logic [1:0]       sel;
  logic             lu_q, lu_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  load_use_detect u_lud (
    .rs1_i(bus.id_rs1), .rs2_i(bus.id_rs2), .rs1_used_i(bus.id_rs1_used),
    .rs2_used_i(bus.id_rs2_used), .dst_i(bus.ex_reg_dst), .mem_read_i(bus.ex_mem_read),
    .hit_o(lu_hit)
  );
`ifdef PIPE_HAZARD_CTRL_IRQ_EN
  irq_state_t    state_q, state_d;
  logic [DW-1:0] drain_q, drain_d;
  logic          epc_q, epc_d;
  // interrupt sequencer registers
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      drain_q <= '0;
      epc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      epc_q   <= epc_d;
    end
  // entry is deferred past a taken branch so EPC holds the branch target; busy freezes everything
  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    epc_d   = 1'b0;
    if (!bus.dmem_busy)
      case (state_q)
        IDLE:    if (bus.irq && !bus.ex_branch_taken) begin
                   state_d = DRAIN;
                   drain_d = DW'(DRAIN_CYCLES - 1);
                   epc_d   = 1'b1;
                 end
        DRAIN:   if (drain_q == '0) state_d = VECTOR;
                 else drain_d = drain_q - 1'b1;
        VECTOR:  state_d = ISR;
        default: if (bus.ex_eret) state_d = IDLE;
      endcase
  end
  assign in_drain        = state_q == DRAIN;
  assign in_vec          = state_q == VECTOR;
  assign eret_hit        = state_q == ISR && bus.ex_eret;
  assign bus.epc_capture = epc_q;
  assign bus.irq_ack     = in_vec && !bus.dmem_busy;
  assign bus.int_active  = state_q == ISR;
`else
  logic          unused_irq;
  logic [DW-1:0] unused_drain;
  assign unused_irq      = bus.irq ^ bus.ex_eret;
  assign unused_drain    = '0;
  assign in_drain        = 1'b0;
  assign in_vec          = 1'b0;
  assign eret_hit        = 1'b0;
  assign bus.epc_capture = 1'b0;
  assign bus.irq_ack     = 1'b0;
  assign bus.int_active  = 1'b0;
`endif
  // priority: memory wait, interrupt sequencing, redirect (branch/eret), load-use bubble
  always_comb begin
    sif  = 1'b0;
    fif  = 1'b0;
    fid  = 1'b0;
    fem  = 1'b0;
    hold = 1'b0;
    sel  = PC_SEL_SEQ;
    if (bus.dmem_busy) begin
      sif  = 1'b1;
      hold = 1'b1;
    end else if (in_drain) begin
      fif  = 1'b1;
      fid  = 1'b1;
      hold = 1'b1;
    end else if (in_vec) sel = PC_SEL_VEC;
    else if (eret_hit || bus.ex_branch_taken) begin
      fif = 1'b1;
      fid = 1'b1;
      fem = lu_q;
      sel = eret_hit ? PC_SEL_EPC : PC_SEL_BR;
    end else if (lu_hit) begin
      sif  = 1'b1;
      hold = 1'b1;
      fid  = 1'b1;
    end
  end
  assign lu_d = bus.dmem_busy ? lu_q : sif;
  assign cnt_d = (sif && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
  // lu_q marks the load-use bubble now heading into MEM; cnt_q is the saturating stall counter
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      lu_q  <= 1'b0;
      cnt_q <= '0;
    end else begin
      lu_q  <= lu_d;
      cnt_q <= cnt_d;
    end
  assign bus.stall_if_id  = sif;
  assign bus.stall_id_ex  = bus.dmem_busy;
  assign bus.stall_ex_mem = bus.dmem_busy;
  assign bus.stall_mem_wb = bus.dmem_busy;
  assign bus.flush_if_id  = fif;
  assign bus.flush_id_ex  = fid;
  assign bus.flush_ex_mem = fem;
  assign bus.pc_hold      = hold;
  assign bus.pc_sel       = sel;
  assign bus.stall_cnt    = cnt_q;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed vectors with a queued scoreboard checked by a negedge monitor
module tb_pipe_hazard_ctrl;
  typedef struct packed {
    logic [3:0] rs1, rs2;
    logic       u1, u2;
    logic [3:0] dst;
    logic       mr, br, er, busy, irq;
  } stim_t;
  typedef struct {
    logic [12:0] e;
    logic [3:0]  c;
    string       nm;
  } exp_t;
  localparam logic [12:0] NONE = 13'b0;
  localparam logic [12:0] LU   = 13'b1_000_0_1_0_1_00_000;
  localparam logic [12:0] BR   = 13'b0_000_1_1_0_0_01_000;
  localparam logic [12:0] FEM  = 13'b0_000_0_0_1_0_00_000;
  localparam logic [12:0] BUSY = 13'b1_111_0_0_0_1_00_000;
  localparam logic [12:0] DRN  = 13'b0_000_1_1_0_1_00_000;
  localparam logic [12:0] EPC  = 13'b0_000_0_0_0_0_00_100;
  localparam logic [12:0] VEC  = 13'b0_000_0_0_0_0_10_010;
  localparam logic [12:0] ACT  = 13'b0_000_0_0_0_0_00_001;
  localparam logic [12:0] ERET = 13'b0_000_1_1_0_0_11_001;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int errors = 0;
  int checks = 0;
  logic [3:0] ec = 4'd0;
  exp_t q[$];
  pipe_hazard_ctrl_if #(.CNT_W(4)) bus();
  pipe_hazard_ctrl #(.DRAIN_CYCLES(3), .CNT_W(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  function automatic stim_t mk(input logic [3:0] rs1, rs2, input logic u1, u2,
                               input logic [3:0] dst, input logic mr, br, er, busy, irq);
    return {rs1, rs2, u1, u2, dst, mr, br, er, busy, irq};
  endfunction
  task automatic drive(input logic rn, input stim_t s, input logic [12:0] e, input string nm);
    exp_t x;
    @(posedge clk);
    #1;
    rst_n = rn;
    bus.id_rs1 = s.rs1;
    bus.id_rs2 = s.rs2;
    bus.id_rs1_used = s.u1;
    bus.id_rs2_used = s.u2;
    bus.ex_reg_dst = s.dst;
    bus.ex_mem_read = s.mr;
    bus.ex_branch_taken = s.br;
    bus.ex_eret = s.er;
    bus.dmem_busy = s.busy;
    bus.irq = s.irq;
    if (!rn) ec = 4'd0;
    x.e = e;
    x.c = ec;
    x.nm = nm;
    q.push_back(x);
    if (rn && e[12]) ec = (ec == 4'hF) ? ec : ec + 4'd1;
  endtask
  always @(negedge clk) begin
    exp_t x;
    logic [12:0] a;
    if (q.size() != 0) begin
      x = q.pop_front();
      a = {bus.stall_if_id, bus.stall_id_ex, bus.stall_ex_mem, bus.stall_mem_wb,
           bus.flush_if_id, bus.flush_id_ex, bus.flush_ex_mem, bus.pc_hold, bus.pc_sel,
           bus.epc_capture, bus.irq_ack, bus.int_active};
      checks += 2;
      if (a !== x.e) begin
        errors++;
        $display("FAIL %s ctrl actual=%b required=%b", x.nm, a, x.e);
      end
      if (bus.stall_cnt !== x.c) begin
        errors++;
        $display("FAIL %s stall_cnt actual=%0d required=%0d", x.nm, bus.stall_cnt, x.c);
      end
    end
  end
  initial begin
    stim_t z;
    z = '0;
    drive(1'b0, z, NONE, "reset");
    drive(1'b1, z, NONE, "idle");
    drive(1'b1, mk(1, 5, 1, 1, 5, 1, 0, 0, 0, 0), LU, "lu_rs2");
    drive(1'b1, mk(1, 5, 1, 1, 0, 0, 0, 0, 0, 0), NONE, "lu_after");
    drive(1'b1, mk(0, 0, 1, 1, 0, 1, 0, 0, 0, 0), NONE, "lu_r0");
    drive(1'b1, mk(7, 2, 0, 1, 7, 1, 0, 0, 0, 0), NONE, "lu_unused");
    drive(1'b1, mk(7, 2, 1, 0, 7, 1, 0, 0, 0, 0), LU, "lu_rs1");
    drive(1'b1, z, NONE, "lu_clear");
    drive(1'b1, mk(7, 2, 1, 0, 7, 1, 1, 0, 0, 0), BR, "br_lu");
    drive(1'b1, mk(1, 5, 1, 1, 5, 1, 0, 0, 0, 0), LU, "lu_again");
    drive(1'b1, mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0), BR | FEM, "br_fem");
    drive(1'b1, mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0), BUSY, "busy");
    drive(1'b1, mk(7, 2, 1, 0, 7, 1, 1, 0, 1, 0), BUSY, "busy_pri");
    drive(1'b1, z, NONE, "post_busy");
`ifdef PIPE_HAZARD_CTRL_IRQ_EN
    drive(1'b1, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1), NONE, "irq_req");
    drive(1'b1, z, DRN | EPC, "drain0");
    drive(1'b1, z, DRN, "drain1");
    drive(1'b1, z, DRN, "drain2");
    drive(1'b1, z, VEC, "vector");
    drive(1'b1, z, ACT, "isr");
    drive(1'b1, mk(1, 5, 1, 1, 5, 1, 0, 0, 0, 0), LU | ACT, "isr_lu");
    drive(1'b1, z, ACT, "isr_idle");
    drive(1'b1, mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0), ERET, "eret");
    drive(1'b1, z, NONE, "post_eret");
    drive(1'b1, mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 1), BR, "irq_br_defer");
    drive(1'b1, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1), NONE, "irq_accept");
    drive(1'b1, z, DRN | EPC, "b_drain0");
    drive(1'b1, mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0), BUSY, "drain_busy0");
    drive(1'b1, mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0), BUSY, "drain_busy1");
    drive(1'b1, z, DRN, "b_drain1");
    drive(1'b1, z, DRN, "b_drain2");
    drive(1'b1, z, VEC, "b_vector");
    drive(1'b1, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1), ACT, "isr_masked");
    drive(1'b0, z, NONE, "rst_in_isr");
`else
    drive(1'b1, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1), NONE, "irq_off0");
    drive(1'b1, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1), NONE, "irq_off1");
    drive(1'b1, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1), NONE, "irq_off2");
    drive(1'b1, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1), NONE, "irq_off3");
    drive(1'b1, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1), NONE, "irq_off4");
    drive(1'b0, z, NONE, "rst_mid");
`endif
    drive(1'b1, mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0), NONE, "eret_idle");
    for (int i = 0; i < 17; i++) drive(1'b1, mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0), BUSY, "sat_busy");
    drive(1'b1, z, NONE, "sat_final");
    @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain_queue actual=%0d required=0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Central hazard and sequencing controller for the 5-stage CPU pipeline. It generates every stall and flush for the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers and drives PC hold and PC select. It covers load-use hazards, taken branches resolved in EX, data-memory wait states and interrupt entry/return. It sits beside the hazard/bypass logic in ID and consumes status from EX and MEM.

## Interface
- DRAIN_CYCLES, 3: cycles spent retiring EX/MEM/WB contents before vectoring to an interrupt.
- CNT_W, 16: width of the saturating stall-cycle counter.
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- id_rs1, id_rs2  in  4 each  source registers of the instruction in ID.
- id_rs1_used, id_rs2_used  in  1 each  source actually read.
- ex_reg_dst  in  4  destination of the instruction in EX.
- ex_mem_read  in  1  instruction in EX is a load.
- ex_branch_taken  in  1  branch/jump in EX redirects the PC.
- ex_eret  in  1  return-from-interrupt in EX.
- dmem_busy  in  1  data memory is not ready; the MEM access must be repeated.
- irq  in  1  level interrupt request.
- stall_if_id, stall_id_ex, stall_ex_mem, stall_mem_wb  out  1 each  hold the register.
- flush_if_id, flush_id_ex, flush_ex_mem  out  1 each  load a bubble (zeros).
- pc_hold  out  1  PC is not updated.
- pc_sel  out  2  0 sequential, 1 branch target, 2 interrupt vector, 3 EPC.
- epc_capture  out  1  one-cycle strobe telling the datapath to save the ID-stage PC as EPC.
- irq_ack  out  1  one-cycle acknowledge pulse.
- int_active  out  1  handler running; further irq is masked.
- stall_cnt  out  CNT_W  count of stall cycles.

## Operation
- Priority, highest first: dmem_busy, then the interrupt FSM, then ex_branch_taken, then load-use.
- dmem_busy: assert all four stall_* and pc_hold. No flush is asserted. The FSM and the drain counter freeze.
- Load-use condition: ex_mem_read and ex_reg_dst≠0, and ex_reg_dst matches id_rs1 with id_rs1_used, or matches id_rs2 with id_rs2_used.
  - Response: stall_if_id, pc_hold and flush_id_ex for exactly one cycle.
  - Forwarding resolves the hazard on the next cycle.
- Taken branch: flush_if_id, flush_id_ex, pc_sel=1. A load-use condition in the same cycle is ignored, because the instruction in ID is being flushed.
- Interrupt FSM states are IDLE, DRAIN, VECTOR and ISR.
  - IDLE→DRAIN: irq=1, not int_active, and ex_branch_taken=0. If a branch is taken that cycle, acceptance is deferred one cycle so that EPC is the branch target.
  - IDLE→DRAIN entry cycle: epc_capture=1.
  - DRAIN: flush_if_id, flush_id_ex and pc_hold are held. The counter loads DRAIN_CYCLES-1 and decrements each non-busy cycle. The FSM moves to VECTOR when the counter reaches 0.
  - VECTOR (1 cycle): pc_sel=2, irq_ack=1. Next state is ISR.
  - ISR: int_active=1. On ex_eret the block asserts flush_if_id, flush_id_ex and pc_sel=3, then returns to IDLE.
- flush_ex_mem is asserted only when ex_eret or ex_branch_taken coincides with a load-use bubble in the MEM-bound slot; otherwise it is 0.
- stall_cnt increments on every cycle in which stall_if_id=1, for any cause. It saturates at all-ones.

## Timing
- All stall, flush, pc_sel and pc_hold outputs are combinational from the current inputs and the registered FSM state. They are valid in the same cycle as the inputs that cause them.
- irq_ack, epc_capture and int_active are driven from registered state, with no combinational path from irq.
- Latency from irq to pc_sel=2 is DRAIN_CYCLES+1 cycles, plus one cycle per dmem_busy cycle.
- Reset values:
  - All outputs are 0, pc_sel=0 and stall_cnt=0.
  - The FSM is in IDLE and the drain counter is 0.
  - Reset mid-drain or mid-ISR returns to IDLE immediately and no irq_ack is issued.
- irq deasserted during DRAIN does not abort: the block still vectors. The handler decides what to do with a spurious entry.
- ex_eret while not in ISR is ignored.

## Configuration
- PIPE_HAZARD_CTRL_IRQ_EN defined: the interrupt FSM, drain counter and eret path are present.
- PIPE_HAZARD_CTRL_IRQ_EN undefined:
  - irq and ex_eret are ignored.
  - irq_ack, epc_capture and int_active are tied 0.
  - pc_sel never takes the values 2 or 3.

## Structure
- pipe_ctrl_pkg holds:
  - the irq_state_t enum (IDLE, DRAIN, VECTOR, ISR);
  - the PC_SEL_SEQ, PC_SEL_BR, PC_SEL_VEC and PC_SEL_EPC constants;
  - REG_ZERO=4'd0.
- One sub-module, load_use_detect, is a purely combinational comparator that produces the load-use condition.

## Test plan
- Load r5 in EX, with ID reading r5 through rs2 → one cycle of stall_if_id=1, flush_id_ex=1 and pc_hold=1, then normal flow; stall_cnt=1.
- Load to r0 in EX, with ID reading r0 → no stall.
- ex_branch_taken=1 together with a load-use hit → flush_if_id=1, flush_id_ex=1, pc_sel=1, stall_if_id=0.
- irq=1 in IDLE with DRAIN_CYCLES=3 → epc_capture on cycle 0, flushes during cycles 0-2, pc_sel=2 and irq_ack on cycle 3, int_active from cycle 4.
- dmem_busy held for 2 cycles during DRAIN → all stall_*=1 and the VECTOR cycle is delayed by 2 cycles.
- ex_eret in ISR → pc_sel=3 and the flushes, int_active=0 on the next cycle; a following irq is accepted again.
